// File: rtl/dcacheread_arbiter_if.sv
// Bundle of the two requester ports and the cache-side read port of the data-cache read arbiter.
// The slave modport is the arbiter's view of the bus; master is the environment's view.
interface dcacheread_arbiter_if;
    logic        r0_do;
    logic        r0_done;
    logic [3:0]  r0_length;
    logic        r0_cache_disable;
    logic [31:0] r0_address;
    logic [63:0] r0_data;

    logic        r1_do;
    logic        r1_done;
    logic [3:0]  r1_length;
    logic        r1_cache_disable;
    logic [31:0] r1_address;
    logic [63:0] r1_data;

    logic        resp_do;
    logic        resp_done;
    logic [3:0]  resp_length;
    logic        resp_cache_disable;
    logic [31:0] resp_address;
    logic [63:0] resp_data;

    logic        busy;
    logic        owner;

    modport slave (
        input  r0_do, r0_length, r0_cache_disable, r0_address,
        output r0_done, r0_data,
        input  r1_do, r1_length, r1_cache_disable, r1_address,
        output r1_done, r1_data,
        output resp_do, resp_length, resp_cache_disable, resp_address,
        input  resp_done, resp_data,
        output busy, owner
    );

    modport master (
        output r0_do, r0_length, r0_cache_disable, r0_address,
        input  r0_done, r0_data,
        output r1_do, r1_length, r1_cache_disable, r1_address,
        input  r1_done, r1_data,
        input  resp_do, resp_length, resp_cache_disable, resp_address,
        output resp_done, resp_data,
        input  busy, owner
    );
endinterface

// File: rtl/dcacheread_arbiter.sv
// Two-requester arbiter/sequencer for the single data-cache read port.
// Define DCACHEREAD_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
//
// state | meaning
// IDLE  | no transaction; grant on the next edge if any request is up
// BUSY0 | cache read running on behalf of requester 0
// BUSY1 | cache read running on behalf of requester 1
module dcacheread_arbiter (
    input  logic                 clk,
    input  logic                 rst_n,
    dcacheread_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  len_q, len_d;
    logic        cd_q, cd_d;
    logic [31:0] addr_q, addr_d;
    logic        abort_q, abort_d;

    logic any_req;
    logic win;
    logic owner_do;

    assign any_req  = bus.r0_do | bus.r1_do;
    assign owner_do = (state_q == BUSY1) ? bus.r1_do : bus.r0_do;

`ifdef DCACHEREAD_ARB_RR_EN
    logic prio_q, prio_d;

    // A lone requester always wins; prio_q only breaks ties.
    assign win = (bus.r0_do & bus.r1_do) ? prio_q : bus.r1_do;
`else
    assign win = ~bus.r0_do;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cd_d    = cd_q;
        addr_d  = addr_q;
        abort_d = abort_q;
`ifdef DCACHEREAD_ARB_RR_EN
        prio_d  = prio_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = win ? BUSY1 : BUSY0;
                    len_d   = win ? bus.r1_length        : bus.r0_length;
                    cd_d    = win ? bus.r1_cache_disable : bus.r0_cache_disable;
                    addr_d  = win ? bus.r1_address       : bus.r0_address;
                    abort_d = 1'b0;
`ifdef DCACHEREAD_ARB_RR_EN
                    prio_d  = ~win;
`endif
                end
            end
            BUSY0, BUSY1: begin
                // A withdrawn request still lets the cache finish; only the done is swallowed.
                if (bus.resp_done) begin
                    state_d = IDLE;
                end else if (!owner_do) begin
                    abort_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= 4'd0;
            cd_q    <= 1'b0;
            addr_q  <= 32'd0;
            abort_q <= 1'b0;
`ifdef DCACHEREAD_ARB_RR_EN
            prio_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cd_q    <= cd_d;
            addr_q  <= addr_d;
            abort_q <= abort_d;
`ifdef DCACHEREAD_ARB_RR_EN
            prio_q  <= prio_d;
`endif
        end
    end

    assign bus.resp_do            = (state_q != IDLE);
    assign bus.resp_length        = len_q;
    assign bus.resp_cache_disable = cd_q;
    assign bus.resp_address       = addr_q;

    assign bus.r0_done = (state_q == BUSY0) & bus.resp_done & ~abort_q & bus.r0_do;
    assign bus.r1_done = (state_q == BUSY1) & bus.resp_done & ~abort_q & bus.r1_do;
    assign bus.r0_data = bus.resp_data;
    assign bus.r1_data = bus.resp_data;

    assign bus.busy  = (state_q != IDLE);
    assign bus.owner = (state_q == BUSY1);

endmodule

// File: tb/tb_dcacheread_arbiter.sv
// Self-checking bench for dcacheread_arbiter: directed test-plan steps followed by random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_dcacheread_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcacheread_arbiter_if bus ();

    dcacheread_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the port (-1 = nobody), the captured request, withdrawal flag.
    int          m_own  = -1;
    int          m_last = -1;
    logic [3:0]  m_len  = 4'd0;
    logic        m_cd   = 1'b0;
    logic [31:0] m_addr = 32'd0;
    bit          m_wd   = 1'b0;
`ifdef DCACHEREAD_ARB_RR_EN
    bit          m_rr   = 1'b0;
`endif
    bit          e_done0, e_done1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check all outputs mid-cycle, then advance the model across one rising edge.
    task automatic step();
        int w;
        #1;
        e_done0 = (m_own == 0) && bus.resp_done && !m_wd && bus.r0_do;
        e_done1 = (m_own == 1) && bus.resp_done && !m_wd && bus.r1_do;
        chk("resp_do",      bus.resp_do,            m_own >= 0);
        chk("resp_length",  bus.resp_length,        m_len);
        chk("resp_cd",      bus.resp_cache_disable, m_cd);
        chk("resp_address", bus.resp_address,       m_addr);
        chk("busy",         bus.busy,               m_own >= 0);
        chk("owner",        bus.owner,              m_own == 1);
        chk("r0_done",      bus.r0_done,            e_done0);
        chk("r1_done",      bus.r1_done,            e_done1);
        chk("r0_data",      bus.r0_data,            bus.resp_data);
        chk("r1_data",      bus.r1_data,            bus.resp_data);
        @(posedge clk);
        if (!rst_n) begin
            m_own  = -1;
            m_len  = 4'd0;
            m_cd   = 1'b0;
            m_addr = 32'd0;
            m_wd   = 1'b0;
`ifdef DCACHEREAD_ARB_RR_EN
            m_rr   = 1'b0;
`endif
        end else if (m_own < 0) begin
            if (bus.r0_do || bus.r1_do) begin
                if (bus.r0_do && bus.r1_do) begin
`ifdef DCACHEREAD_ARB_RR_EN
                    w = m_rr ? 1 : 0;
`else
                    w = 0;
`endif
                end else begin
                    w = bus.r1_do ? 1 : 0;
                end
                m_own  = w;
                m_len  = (w == 1) ? bus.r1_length        : bus.r0_length;
                m_cd   = (w == 1) ? bus.r1_cache_disable : bus.r0_cache_disable;
                m_addr = (w == 1) ? bus.r1_address       : bus.r0_address;
                m_wd   = 1'b0;
`ifdef DCACHEREAD_ARB_RR_EN
                m_rr   = (w == 0);
`endif
            end
        end else if (bus.resp_done) begin
            m_last = m_own;
            m_own  = -1;
        end else if (!((m_own == 1) ? bus.r1_do : bus.r0_do)) begin
            m_wd = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.r0_do = 1'b0; bus.r0_length = 4'd0; bus.r0_cache_disable = 1'b0; bus.r0_address = 32'd0;
        bus.r1_do = 1'b0; bus.r1_length = 4'd0; bus.r1_cache_disable = 1'b0; bus.r1_address = 32'd0;
        bus.resp_done = 1'b0; bus.resp_data = 64'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        // Reset state
        step();
        chk("rst_resp_do", bus.resp_do, 1'b0);
        chk("rst_owner",   bus.owner,   1'b0);
        rst_n = 1'b1;
        step();

        // Single r0 read; address change while owned must be ignored
        bus.r0_do = 1'b1; bus.r0_address = 32'h0000_1004; bus.r0_length = 4'd4;
        step();
        chk("t1_resp_do_rise", bus.resp_do, 1'b1);
        bus.r0_address = 32'hDEAD_0000;
        step();
        chk("t1_addr_held", bus.resp_address, 32'h0000_1004);
        step();
        bus.resp_done = 1'b1; bus.resp_data = 64'h1122_3344_5566_7788;
        #1;
        chk("t1_r0_done", bus.r0_done, 1'b1);
        chk("t1_r0_data", bus.r0_data, 64'h1122_3344_5566_7788);
        chk("t1_r1_done", bus.r1_done, 1'b0);
        step();
        bus.resp_done = 1'b0; bus.r0_do = 1'b0;
        step();

        // Simultaneous requests: two transactions separated by a bubble
        bus.r0_do = 1'b1; bus.r0_address = 32'h0000_0100; bus.r0_length = 4'd8;
        bus.r1_do = 1'b1; bus.r1_address = 32'h0000_0200; bus.r1_length = 4'd2; bus.r1_cache_disable = 1'b1;
        step();
`ifndef DCACHEREAD_ARB_RR_EN
        chk("t2_first_owner", bus.owner, 1'b0);
`endif
        step();
        bus.resp_done = 1'b1; bus.resp_data = 64'hA5A5_0000_1111_2222;
        step();
        bus.resp_done = 1'b0;
        if (m_last == 0) bus.r0_do = 1'b0; else bus.r1_do = 1'b0;
        chk("t2_bubble", bus.resp_do, 1'b0);
        step();
        chk("t2_second_grant", bus.resp_do, 1'b1);
`ifndef DCACHEREAD_ARB_RR_EN
        chk("t2_second_owner", bus.owner, 1'b1);
`endif
        step();
        bus.resp_done = 1'b1; bus.resp_data = 64'h0BAD_F00D_CAFE_BEEF;
        step();
        bus.resp_done = 1'b0; bus.r0_do = 1'b0; bus.r1_do = 1'b0; bus.r1_cache_disable = 1'b0;
        step();

        // Withdrawal: done is swallowed but the cache transaction finishes
        bus.r0_do = 1'b1; bus.r0_address = 32'h0000_3000; bus.r0_length = 4'd1;
        step();
        step();
        bus.r0_do = 1'b0;
        step();
        step();
        step();
        chk("t3_resp_do_held", bus.resp_do, 1'b1);
        bus.resp_done = 1'b1; bus.resp_data = 64'h1234_5678_9ABC_DEF0;
        #1;
        chk("t3_r0_done_swallowed", bus.r0_done, 1'b0);
        step();
        bus.resp_done = 1'b0;
        chk("t3_back_idle", bus.busy, 1'b0);
        step();

        // Reset while BUSY1, then a stray cache done
        bus.r1_do = 1'b1; bus.r1_address = 32'h2000_0008; bus.r1_length = 4'd8; bus.r1_cache_disable = 1'b1;
        step();
        chk("t4_owner1", bus.owner, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; bus.r1_do = 1'b0;
        chk("t4_resp_do", bus.resp_do, 1'b0);
        chk("t4_busy", bus.busy, 1'b0);
        chk("t4_len_clr", bus.resp_length, 4'd0);
        chk("t4_addr_clr", bus.resp_address, 32'd0);
        chk("t4_cd_clr", bus.resp_cache_disable, 1'b0);
        bus.resp_done = 1'b1;
        #1;
        chk("t4_stray_r0", bus.r0_done, 1'b0);
        chk("t4_stray_r1", bus.r1_done, 1'b0);
        step();
        bus.resp_done = 1'b0;
        step();

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            if (bus.r0_do) begin
                if (e_done0) bus.r0_do = 1'($urandom_range(0, 1));
                else if ($urandom_range(0, 15) == 0) bus.r0_do = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    bus.r0_address = $urandom; bus.r0_length = 4'($urandom_range(1, 8));
                    bus.r0_cache_disable = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.r0_do = 1'b1; bus.r0_address = $urandom; bus.r0_length = 4'($urandom_range(1, 8));
                bus.r0_cache_disable = 1'($urandom_range(0, 1));
            end
            if (bus.r1_do) begin
                if (e_done1) bus.r1_do = 1'($urandom_range(0, 1));
                else if ($urandom_range(0, 15) == 0) bus.r1_do = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    bus.r1_address = $urandom; bus.r1_length = 4'($urandom_range(1, 8));
                    bus.r1_cache_disable = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.r1_do = 1'b1; bus.r1_address = $urandom; bus.r1_length = 4'($urandom_range(1, 8));
                bus.r1_cache_disable = 1'($urandom_range(0, 1));
            end
            bus.resp_done = ($urandom_range(0, 3) == 0);
            bus.resp_data = {$urandom, $urandom};
            rst_n = ($urandom_range(0, 79) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
